dmem_responder: RTL and testbench

Word-addressed data-memory responder that serves the pipeline CPU's load/store port through a request/response handshake with programmable wait states. It sits in the MEM stage in place of the zero-latency data RAM and drives a stall signal that freezes the pipeline while an access is outstanding. It supports byte-lane writes and reports misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_byte_merge.sv | 24 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, counter width
// and the access legality check.
package dmem_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int CNT_W = $clog2(16);

   // Misaligned word access or a word index beyond the array is an error.
   function automatic logic addrErr(input logic [31:0] addr, input int depth);
      logic misaligned;
      logic outOfRange;
      misaligned = (addr[1:0] != 2'b00);
      outOfRange = ({2'b00, addr[31:2]} >= $unsigned(depth));
      return misaligned || outOfRange;
   endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Byte-lane merge for partial stores: each enabled lane takes the store data,
// the rest keep the current word contents.
module dmem_byte_merge
   import dmem_pkg::*;
(
   input  logic [31:0] oldWord,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] newWord
);

   // Lane-wise select between stored and incoming bytes.
   always_comb begin
      newWord = oldWord;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            newWord[8*i +: 8] = wdata[8*i +: 8];
         end else begin
            newWord[8*i +: 8] = oldWord[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with request/response handshake,
// programmable wait states, byte-lane stores and error reporting.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_stall
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]       stateR;
   logic [CNT_W-1:0] cntR;
   logic             weR;
   logic [31:0]      addrR;
   logic [31:0]      wdataR;
   logic [3:0]       beR;
   logic [31:0]      memR [DEPTH];

   logic             acceptS;
   logic             goRespS;
   logic             accWeS;
   logic             accErrS;
   logic [31:0]      accAddrS;
   logic [31:0]      accWdataS;
   logic [3:0]       accBeS;
   logic [IDX_W-1:0] accIdxS;
   logic [31:0]      oldWordS;
   logic [31:0]      newWordS;

   assign ready     = reset && (stateR == ST_IDLE);
   assign acceptS   = req && ready;
   assign mem_stall = acceptS || (stateR == ST_WAIT);

   // With zero wait states the access happens on the accept edge, so the live
   // request fields are used instead of the (not yet loaded) capture registers.
   always_comb begin
      if (stateR == ST_IDLE) begin
         accWeS    = we;
         accAddrS  = addr;
         accWdataS = wdata;
         accBeS    = be;
      end else begin
         accWeS    = weR;
         accAddrS  = addrR;
         accWdataS = wdataR;
         accBeS    = beR;
      end
   end

   assign accErrS  = addrErr(accAddrS, DEPTH);
   assign accIdxS  = accAddrS[IDX_W+1:2];
   assign oldWordS = memR[accIdxS];

   // Asserted for the edge that moves the FSM into RESP; never while in reset.
   always_comb begin
      goRespS = 1'b0;
      if (!reset) begin
         goRespS = 1'b0;
      end else if (stateR == ST_IDLE) begin
         goRespS = acceptS && (WAIT_CYCLES == 0);
      end else if (stateR == ST_WAIT) begin
         goRespS = (cntR == CNT_W'(0));
      end else begin
         goRespS = 1'b0;
      end
   end

   dmem_byte_merge uMerge (
      .oldWord (oldWordS),
      .wdata   (accWdataS),
      .be      (accBeS),
      .newWord (newWordS)
   );

   // FSM, wait counter, capture registers and registered response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateR <= ST_IDLE;
         cntR   <= CNT_W'(0);
         weR    <= 1'b0;
         addrR  <= 32'h0000_0000;
         wdataR <= 32'h0000_0000;
         beR    <= 4'b0000;
         rvalid <= 1'b0;
         rdata  <= 32'h0000_0000;
         err    <= 1'b0;
      end else begin
         rvalid <= goRespS;
         err    <= goRespS && accErrS;
         rdata  <= (goRespS && !accWeS && !accErrS) ? oldWordS : 32'h0000_0000;
         case (stateR)
            ST_IDLE: begin
               if (acceptS) begin
                  weR    <= we;
                  addrR  <= addr;
                  wdataR <= wdata;
                  beR    <= be;
                  if (WAIT_CYCLES > 0) begin
                     stateR <= ST_WAIT;
                     cntR   <= CNT_W'(WAIT_CYCLES - 1);
                  end else begin
                     stateR <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (cntR == CNT_W'(0)) begin
                  stateR <= ST_RESP;
               end else begin
                  cntR <= cntR - CNT_W'(1);
               end
            end
            ST_RESP: stateR <= ST_IDLE;
            default: stateR <= ST_IDLE;
         endcase
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (goRespS && accWeS && !accErrS) begin
         memR[accIdxS] <= newWordS;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with none, checked with immediate assertions at fixed cycle points.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqA, weA, readyA, rvalidA, errA, stallA;
   logic [31:0] addrA, wdataA, rdataA;
   logic [3:0]  beA;
   logic        reqB, weB, readyB, rvalidB, errB, stallB;
   logic [31:0] addrB, wdataB, rdataB;
   logic [3:0]  beB;

   int nAssert = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dutA (
      .clk(clk), .reset(reset), .req(reqA), .we(weA), .addr(addrA), .wdata(wdataA),
      .be(beA), .ready(readyA), .rvalid(rvalidA), .rdata(rdataA), .err(errA),
      .mem_stall(stallA)
   );

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dutB (
      .clk(clk), .reset(reset), .req(reqB), .we(weB), .addr(addrB), .wdata(wdataB),
      .be(beB), .ready(readyB), .rvalid(rvalidB), .rdata(rdataB), .err(errB),
      .mem_stall(stallB)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Full handshake on the two-wait-state instance, starting and ending at a negedge in IDLE.
   task automatic accessA(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic expErr, input logic [31:0] expData);
      reqA = 1'b1; weA = w; addrA = a; wdataA = d; beA = b;
      #1;
      chk1({tag, " ready@T"}, readyA, 1'b1);
      chk1({tag, " stall@T"}, stallA, 1'b1);
      @(negedge clk);
      reqA = 1'b0;
      chk1({tag, " stall@T+1"}, stallA, 1'b1);
      chk1({tag, " rvalid@T+1"}, rvalidA, 1'b0);
      @(negedge clk);
      chk1({tag, " stall@T+2"}, stallA, 1'b1);
      chk1({tag, " rvalid@T+2"}, rvalidA, 1'b0);
      @(negedge clk);
      chk1({tag, " rvalid@T+3"}, rvalidA, 1'b1);
      chk1({tag, " stall@T+3"}, stallA, 1'b0);
      chk1({tag, " ready@T+3"}, readyA, 1'b0);
      chk1({tag, " err"}, errA, expErr);
      chk32({tag, " rdata"}, rdataA, expData);
      @(negedge clk);
      chk1({tag, " rvalid@T+4"}, rvalidA, 1'b0);
      chk32({tag, " rdata@T+4"}, rdataA, 32'h0000_0000);
   endtask

   initial begin
      reset = 1'b0;
      reqA = 1'b1; weA = 1'b0; addrA = 32'h0; wdataA = 32'h0; beA = 4'h0;
      reqB = 1'b1; weB = 1'b0; addrB = 32'h0; wdataB = 32'h0; beB = 4'h0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("rst ready", readyA, 1'b0);
         chk1("rst rvalid", rvalidA, 1'b0);
         chk32("rst rdata", rdataA, 32'h0);
         chk1("rst err", errA, 1'b0);
         chk1("rst stall", stallA, 1'b0);
         chk1("rst stallB", stallB, 1'b0);
      end
      reqA = 1'b0; reqB = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk1("post-rst ready", readyA, 1'b1);
      chk1("post-rst readyB", readyB, 1'b1);

      accessA("st full",   1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 1'b0, 32'h0);
      accessA("ld full",   1'b0, 32'h10,  32'h0,        4'b0000, 1'b0, 32'hDEADBEEF);
      accessA("st lane1",  1'b1, 32'h10,  32'h0000AA00, 4'b0010, 1'b0, 32'h0);
      accessA("ld lane1",  1'b0, 32'h10,  32'h0,        4'b1111, 1'b0, 32'hDEADAAEF);
      accessA("st word0",  1'b1, 32'h0,   32'h11111111, 4'b1111, 1'b0, 32'h0);
      accessA("ld misal",  1'b0, 32'h11,  32'h0,        4'b1111, 1'b1, 32'h0);
      accessA("st range",  1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0);
      accessA("st misal",  1'b1, 32'h12,  32'hFFFFFFFF, 4'b1111, 1'b1, 32'h0);
      accessA("ld word0",  1'b0, 32'h0,   32'h0,        4'b1111, 1'b0, 32'h11111111);
      accessA("st be0",    1'b1, 32'h10,  32'h00000000, 4'b0000, 1'b0, 32'h0);
      accessA("ld after",  1'b0, 32'h10,  32'h0,        4'b1111, 1'b0, 32'hDEADAAEF);
      accessA("st 0x20",   1'b1, 32'h20,  32'hCAFEF00D, 4'b1111, 1'b0, 32'h0);

      // Reset while the store sits in WAIT: it must be abandoned.
      reqA = 1'b1; weA = 1'b1; addrA = 32'h20; wdataA = 32'h12345678; beA = 4'b1111;
      @(negedge clk);
      reqA = 1'b0;
      chk1("midrst in wait", stallA, 1'b1);
      reset = 1'b0;
      reqA = 1'b1;
      #1;
      chk1("midrst ready", readyA, 1'b0);
      chk1("midrst stall", stallA, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("midrst rvalid", rvalidA, 1'b0);
      end
      reqA = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk1("midrst rel rvalid", rvalidA, 1'b0);
      chk1("midrst rel ready", readyA, 1'b1);
      accessA("ld 0x20", 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0, 32'hCAFEF00D);

      // Zero-wait instance: one store, then three loads with req held.
      reqB = 1'b1; weB = 1'b1; addrB = 32'h4; wdataB = 32'hA5A5A5A5; beB = 4'b1111;
      #1;
      chk1("B st ready", readyB, 1'b1);
      chk1("B st stall", stallB, 1'b1);
      @(negedge clk);
      chk1("B st rvalid", rvalidB, 1'b1);
      chk1("B st err", errB, 1'b0);
      chk32("B st rdata", rdataB, 32'h0);
      reqB = 1'b0;
      @(negedge clk);
      chk1("B st idle rvalid", rvalidB, 1'b0);
      weB = 1'b0;
      reqB = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("B ld ready", readyB, 1'b1);
         chk1("B ld stall", stallB, 1'b1);
         chk1("B ld idle rvalid", rvalidB, 1'b0);
         @(negedge clk);
         chk1("B ld rvalid", rvalidB, 1'b1);
         chk32("B ld rdata", rdataB, 32'hA5A5A5A5);
         chk1("B resp ready", readyB, 1'b0);
         chk1("B resp stall", stallB, 1'b0);
         @(negedge clk);
      end
      reqB = 1'b0;
      chk1("B end rvalid", rvalidB, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
